inst_fetch_buffer: RTL and testbench

//  Fetch stage upstream of the decode/register-file stage of the risc core. Walks the PC, issues

---
 rtl/inst_fetch_buffer.sv | 104 ++++++++++
 tb/tb_inst_fetch_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
// Fetch stage: walks the PC and issues word reads to instruction memory. In-order responses are
// buffered with their PC in a small FIFO feeding decode. A redirect flushes the FIFO and discards
// responses still in flight.
module inst_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   rsp_pc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] discard_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   slots_used;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_push;
  logic          rsp_retire;
  logic          pop;
  logic [31:0]   redirect_base;

  // Every FIFO slot is pre-reserved by a credit, so the FIFO can never overflow.
  assign slots_used = {1'b0, count_reg} + {1'b0, outstanding_reg} + {1'b0, discard_reg};
  assign imem_req_valid = !reset && !redirect_valid && (slots_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored entirely.
  assign rsp_drop   = imem_rsp_valid && (discard_reg != '0);
  assign rsp_push   = imem_rsp_valid && (discard_reg == '0) && (outstanding_reg != '0);
  assign rsp_retire = rsp_drop || rsp_push;

  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

  assign dec_valid = !reset && (count_reg != '0);
  assign pop       = dec_valid && dec_ready;
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign dec_instr = dec_valid ? instr_mem[rd_ptr_reg] : 32'h0;

  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid && rsp_push) begin
      pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight becomes garbage; a response arriving now is already one of them.
      fetch_pc_reg    <= redirect_base;
      rsp_pc_reg      <= redirect_base;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= '0;
      discard_reg     <= discard_reg + outstanding_reg - CW'(rsp_retire);
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_push);
      if (rsp_drop) begin
        discard_reg <= discard_reg - CW'(1);
      end
      if (rsp_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
        rsp_pc_reg <= rsp_pc_reg + 32'd4;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(rsp_push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Randomised bench for inst_fetch_buffer: an in-order memory model with variable latency, a
// scoreboard of fetched words filled at request time and drained by a decode-side monitor.
module tb_inst_fetch_buffer;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  typedef struct { int due; logic [31:0] data; int gen; } mem_rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } dec_item_t;

  mem_rsp_t    mem_q[$];
  dec_item_t   exp_q[$];
  logic [31:0] pop_log[$];

  int errors = 0, checks = 0;
  int cyc = 0, gen = 0, last_due = 0, fifo_cnt = 0, acc_cnt = 0, pop_total = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit exp_dec_valid = 1'b0, rst_window = 1'b1, prev_reset = 1'b1;
  bit rst_req = 1'b1, force_redir = 1'b0;
  logic [31:0] force_pc = 32'h0;
  int knob_rdy = 100, knob_dec = 100, knob_redir = 0, knob_latmin = 1, knob_latmax = 1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs on the falling edge, check the request side, then advance the model.
  task automatic step();
    mem_rsp_t r;
    bit exp_req_valid;
    int lat, due;
    @(negedge clk);
    cyc++;
    reset          = rst_req;
    imem_req_ready = ($urandom_range(0, 99) < knob_rdy);
    dec_ready      = ($urandom_range(0, 99) < knob_dec);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if (!rst_req && knob_redir > 0 && $urandom_range(0, 99) < knob_redir) begin
      redirect_valid = 1'b1;
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!rst_req && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_q[0].data;
    end
    #1;
    exp_req_valid = !reset && !redirect_valid && (mem_q.size() + fifo_cnt < DEPTH);
    check("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_req_valid});
    if (!reset) check("req_addr", imem_req_addr, exp_pc);
    exp_dec_valid = !reset && (fifo_cnt != 0);
    rst_window    = reset || prev_reset;
    if (reset) begin
      mem_q.delete(); exp_q.delete(); pop_log.delete();
      fifo_cnt = 0; acc_cnt = 0; gen++; exp_pc = RESET_PC;
    end else begin
      if (imem_rsp_valid) begin
        r = mem_q.pop_front();
        if (r.gen == gen && !redirect_valid) fifo_cnt++;
      end
      if (exp_dec_valid && dec_ready && !redirect_valid) fifo_cnt--;
      if (redirect_valid) begin
        gen++; fifo_cnt = 0; exp_q.delete(); pop_log.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (exp_req_valid && imem_req_ready) begin
        lat = $urandom_range(knob_latmin, knob_latmax);
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = due;
        mem_q.push_back('{due: due, data: word_at(exp_pc), gen: gen});
        exp_q.push_back('{pc: exp_pc, instr: word_at(exp_pc)});
        exp_pc += 32'd4;
        acc_cnt++;
      end
    end
    prev_reset = reset;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step(); step();
    rst_req = 1'b0;
  endtask

  task automatic set_knobs(input int rdy, input int dec, input int redir, input int lmin, input int lmax);
    knob_rdy = rdy; knob_dec = dec; knob_redir = redir; knob_latmin = lmin; knob_latmax = lmax;
  endtask

  // Decode-side monitor: pops the scoreboard whenever the DUT hands an instruction to decode.
  initial begin
    dec_item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (rst_window) begin
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
      end
      check("dec_valid", {31'h0, dec_valid}, {31'h0, exp_dec_valid});
      if (dec_valid && dec_ready && !redirect_valid && !reset) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stale_instr: got pc %h with nothing expected (cycle %0d)", dec_pc, cyc);
        end else begin
          it = exp_q.pop_front();
          check("dec_pc", dec_pc, it.pc);
          check("dec_instr", dec_instr, it.instr);
          pop_log.push_back(it.pc);
          pop_total++;
        end
      end
    end
  end

  initial begin
    // Streaming from reset with single-cycle memory.
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    run(12);

    // Decode stalled: credit limits issue to DEPTH requests, then resumes.
    set_knobs(100, 0, 0, 1, 1);
    do_reset();
    run(10);
    check("credit_stop", 32'(acc_cnt), 32'(DEPTH));
    knob_dec = 100;
    run(10);

    // Memory back-pressure.
    set_knobs(30, 80, 0, 1, 2);
    run(40);

    // Redirect to a misaligned PC with two slow responses in flight.
    set_knobs(100, 100, 0, 3, 3);
    do_reset();
    run(2);
    check("inflight_before_redirect", 32'(mem_q.size()), 32'd2);
    force_redir = 1'b1; force_pc = 32'h0000_0043;
    run(12);
    check("redirect_log_len", {31'h0, pop_log.size() > 0}, 32'd1);
    if (pop_log.size() > 0) check("redirect_first_pc", pop_log[0], 32'h0000_0040);

    // Wrap-around of the fetch PC.
    set_knobs(100, 100, 0, 1, 1);
    force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
    run(8);
    check("wrap_log_len", {31'h0, pop_log.size() >= 3}, 32'd1);
    if (pop_log.size() >= 3) begin
      check("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
      check("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
      check("wrap_pc2", pop_log[2], 32'h0000_0000);
    end

    // Reset in the middle of a stream.
    set_knobs(100, 50, 0, 1, 3);
    run(6);
    do_reset();
    run(4);

    // Dense randomised traffic with redirects colliding with responses and pops.
    set_knobs(70, 70, 6, 1, 4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    check("progress", {31'h0, pop_total > 500}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
